mux_serializer: RTL and testbench

- Parallel-in/serial-out stage built around the team's 8:1 mux (`mux8to1`).
- Accepts 8-bit words over a valid/ready handshake and holds each word on the mux data inputs.
- Steps the mux select through all 8 positions and presents the mux output as a serial bit stream with downstream backpressure.
- Sits directly upstream of the mux (drives its I and S inputs) and consumes its Y output.

---
 rtl/mux_serializer_pkg.sv | 12 +
 rtl/mux8to1.sv | 10 +
 rtl/mux_serializer.sv | 88 ++++++++
 tb/tb_mux_serializer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_serializer_pkg.sv
// Shared widths and state encoding for the mux-based parallel-to-serial stage.
package mux_serializer_pkg;

    localparam int SEL_W  = 3;
    localparam int WORD_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/mux8to1.sv
// Team 8:1 multiplexer: Y is the data bit I[S].
module mux8to1 (
    input  logic [7:0] I,
    input  logic [2:0] S,
    output logic       Y
);

    assign Y = I[S];

endmodule

// File: rtl/mux_serializer.sv
// Parallel-in/serial-out stage: holds a word on the 8:1 mux inputs and walks
// the select through all positions, with valid/ready on both sides.
module mux_serializer
    import mux_serializer_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1,
    parameter int SEL_W     = mux_serializer_pkg::SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_bit,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_first,
    output logic              ser_last,
    output logic [SEL_W-1:0]  sel,
    output logic              busy
);

    localparam logic [SEL_W-1:0] START_SEL = LSB_FIRST ? '0 : '1;
    localparam logic [SEL_W-1:0] END_SEL   = LSB_FIRST ? '1 : '0;

    state_t             state_q, state_d;
    logic [WORD_W-1:0]  hold_q, hold_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               bit_accept;

    assign ser_valid  = (state_q == ST_SHIFT);
    assign busy       = ser_valid;
    assign ser_first  = ser_valid && (sel_q == START_SEL);
    assign ser_last   = ser_valid && (sel_q == END_SEL);
    assign bit_accept = ser_valid && ser_ready;
    assign sel        = sel_q;

    // The last-bit accept doubles as an input slot so back-to-back words have no bubble.
    assign in_ready = (state_q == ST_IDLE) || (ser_last && ser_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            sel_q   <= START_SEL;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    hold_d  = in_data;
                    sel_d   = START_SEL;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bit_accept) begin
                    if (!ser_last) begin
                        sel_d = LSB_FIRST ? sel_q + SEL_W'(1) : sel_q - SEL_W'(1);
                    end else if (in_valid) begin
                        hold_d = in_data;
                        sel_d  = START_SEL;
                    end else begin
                        sel_d   = START_SEL;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    mux8to1 u_mux (
        .I(hold_q),
        .S(sel_q[2:0]),
        .Y(ser_bit)
    );

endmodule

// File: tb/tb_mux_serializer.sv
// Scoreboard bench: an LSB-first and an MSB-first serializer share stimulus;
// expected serial streams are queued per instance and popped by a negedge monitor.
module tb_mux_serializer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       ser_ready;

    logic [1:0] in_ready_v, ser_bit_v, ser_valid_v, first_v, last_v, busy_v;
    logic [2:0] sel_l, sel_m;

    int total = 0;
    int bad   = 0;

    // Each entry is the serial stream in emission order, first bit in position 7.
    logic [7:0] exp_q [2][$];
    int         k [2];
    logic [7:0] mon_seq;
    logic [2:0] mon_sel;

    mux_serializer #(.LSB_FIRST(1'b1)) dut_lsb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_v[0]), .ser_bit(ser_bit_v[0]), .ser_valid(ser_valid_v[0]),
        .ser_ready(ser_ready), .ser_first(first_v[0]), .ser_last(last_v[0]),
        .sel(sel_l), .busy(busy_v[0])
    );

    mux_serializer #(.LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready_v[1]), .ser_bit(ser_bit_v[1]), .ser_valid(ser_valid_v[1]),
        .ser_ready(ser_ready), .ser_first(first_v[1]), .ser_last(last_v[1]),
        .sel(sel_m), .busy(busy_v[1])
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
        end
    endtask

    // Queue the expected streams and hold the word until the handshake completes.
    task automatic applyStimulus(input logic [7:0] word, input logic [7:0] s_lsb, input logic [7:0] s_msb);
        bit got = 0;
        in_data  = word;
        in_valid = 1'b1;
        exp_q[0].push_back(s_lsb);
        exp_q[1].push_back(s_msb);
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            got = in_ready_v[0] && rst_n;
            @(posedge clk);
            #1;
        end
        if (!got) checkOutput("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            k[0] = 0;
            k[1] = 0;
        end else begin
            for (int w = 0; w < 2; w++) begin
                if (ser_valid_v[w] && ser_ready) begin
                    if (exp_q[w].size() == 0) begin
                        checkOutput($sformatf("unexpected_bit_w%0d", w), 1, 0);
                    end else begin
                        mon_seq = exp_q[w][0];
                        mon_sel = (w == 0) ? sel_l : sel_m;
                        checkOutput($sformatf("w%0d_bit%0d", w, k[w]), ser_bit_v[w], mon_seq[7-k[w]]);
                        checkOutput($sformatf("w%0d_first%0d", w, k[w]), first_v[w], k[w] == 0);
                        checkOutput($sformatf("w%0d_last%0d", w, k[w]), last_v[w], k[w] == 7);
                        checkOutput($sformatf("w%0d_sel%0d", w, k[w]), mon_sel,
                                    (w == 0) ? k[w] : 7 - k[w]);
                        k[w]++;
                        if (k[w] == 8) begin
                            k[w] = 0;
                            void'(exp_q[w].pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] junk [7];
        logic [3:0] pat;
        logic [2:0] prev_sel;
        logic       prev_bit, prev_acc;
        int         acc, cnt;

        junk = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h69};
        pat  = 4'b1001;

        // Reset with in_valid already high: nothing may be accepted while held.
        rst_n     = 1'b0;
        in_data   = 8'hFF;
        in_valid  = 1'b1;
        ser_ready = 1'b1;
        #12;
        checkOutput("rst_in_ready", in_ready_v, 2'b11);
        checkOutput("rst_ser_valid", ser_valid_v, 2'b00);
        checkOutput("rst_busy", busy_v, 2'b00);
        checkOutput("rst_first_last", {first_v, last_v}, 4'b0000);
        checkOutput("rst_sel_lsb", sel_l, 0);
        checkOutput("rst_sel_msb", sel_m, 7);
        checkOutput("rst_ser_bit", ser_bit_v, 2'b00);
        repeat (2) @(posedge clk);
        #3;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_idle", ser_valid_v, 2'b00);
        @(posedge clk);
        #1;

        $display("[TB] single word 8'h2D");
        applyStimulus(8'h2D, 8'b10110100, 8'b00101101);
        repeat (7) @(posedge clk);
        @(negedge clk);
        checkOutput("t1_busy_last", {busy_v[0], last_v[0]}, 2'b11);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t1_busy_after", busy_v, 2'b00);
        checkOutput("t1_in_ready_after", in_ready_v, 2'b11);
        @(posedge clk);
        #1;

        $display("[TB] back-to-back 8'hA5, 8'h3C");
        fork
            begin
                applyStimulus(8'hA5, 8'b10100101, 8'b10100101);
                applyStimulus(8'h3C, 8'b00111100, 8'b00111100);
            end
            begin
                int c = 0;
                @(negedge clk);
                while (!ser_valid_v[0] && c < 20) begin
                    @(negedge clk);
                    c++;
                end
                if (c >= 20) checkOutput("b2b_start_timeout", 0, 1);
                for (int i = 0; i < 16; i++) begin
                    checkOutput($sformatf("b2b_valid%0d", i), ser_valid_v, 2'b11);
                    checkOutput($sformatf("b2b_in_ready%0d", i), in_ready_v[0], (i % 8) == 7);
                    if (i < 15) @(negedge clk);
                end
            end
        join
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] backpressure on 8'hF0");
        applyStimulus(8'hF0, 8'b00001111, 8'b11110000);
        acc      = 0;
        prev_acc = 1'b1;
        prev_sel = '0;
        prev_bit = 1'b0;
        for (int c = 0; c < 40 && acc < 8; c++) begin
            ser_ready = pat[c % 4];
            @(negedge clk);
            if (!prev_acc) begin
                checkOutput($sformatf("bp_sel_hold%0d", c), sel_l, prev_sel);
                checkOutput($sformatf("bp_bit_hold%0d", c), ser_bit_v[0], prev_bit);
            end
            checkOutput($sformatf("bp_in_ready%0d", c), in_ready_v[0], (acc == 7) && ser_ready);
            prev_sel = sel_l;
            prev_bit = ser_bit_v[0];
            prev_acc = ser_valid_v[0] && ser_ready;
            if (prev_acc) acc++;
            @(posedge clk);
            #1;
        end
        if (acc < 8) checkOutput("bp_timeout", acc, 8);
        ser_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] reset mid-word 8'hFF");
        applyStimulus(8'hFF, 8'hFF, 8'hFF);
        cnt = 0;
        for (int c = 0; c < 20 && cnt < 3; c++) begin
            @(negedge clk);
            if (ser_valid_v[0] && ser_ready) cnt++;
            @(posedge clk);
        end
        #2;
        rst_n = 1'b0;
        exp_q[0].delete();
        exp_q[1].delete();
        #1;
        checkOutput("abort_ser_valid", ser_valid_v, 2'b00);
        checkOutput("abort_busy", busy_v, 2'b00);
        checkOutput("abort_sel_lsb", sel_l, 0);
        checkOutput("abort_sel_msb", sel_m, 7);
        checkOutput("abort_ser_bit", ser_bit_v, 2'b00);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checkOutput("abort_release_idle", ser_valid_v, 2'b00);
        @(posedge clk);
        #1;
        applyStimulus(8'h01, 8'b10000000, 8'b00000001);
        repeat (9) @(posedge clk);
        #1;

        $display("[TB] in_valid mid-word with changing data");
        applyStimulus(8'h96, 8'b01101001, 8'b10010110);
        for (int i = 0; i < 7; i++) begin
            in_data  = junk[i];
            in_valid = 1'b1;
            @(negedge clk);
            checkOutput($sformatf("mid_in_ready%0d", i), in_ready_v[0], 0);
            @(posedge clk);
            #1;
        end
        in_data = 8'h1E;
        exp_q[0].push_back(8'b01111000);
        exp_q[1].push_back(8'b00011110);
        @(negedge clk);
        checkOutput("mid_in_ready_last", in_ready_v, 2'b11);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        checkOutput("lsb_queue_drained", exp_q[0].size(), 0);
        checkOutput("msb_queue_drained", exp_q[1].size(), 0);
        checkOutput("final_idle", busy_v, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
